ext_msg_ram_banked: RTL and testbench

Multi-bank extrinsic message store for the LDPC decoder. It provides NUM_BANKS independent single-port RAM banks, one per parallel check/variable processing lane, and each bank is accessed concurrently. It extends the single-bank extrinsic RAM in three ways: a registered read with a valid strobe, write-first read-during-write, and a built-in clear sequencer. The clear sequencer zeroes all message memory after reset and between codewords without datapath involvement.

---
 rtl/ext_msg_ram_banked.sv | 137 +++++++++++++
 tb/tb_ext_msg_ram_banked.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_msg_ram_banked.sv
// Multi-bank extrinsic message store: NUM_BANKS independent single-port banks with
// registered write-first reads, per-lane valid strobes and a built-in zeroing sequencer.
module ext_msg_ram_banked #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_BANKS-1:0]             chip_sel,
  input  logic [NUM_BANKS-1:0]             write_en,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0]  address,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  data_in,
  input  logic                             clear_req,
  output logic                             clear_busy,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  data_out,
  output logic [NUM_BANKS-1:0]             data_valid
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR_L = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [ADDR_WIDTH-1:0]   clear_addr_r;
  logic [ADDR_WIDTH-1:0]   clear_addr_s;
  logic                    clear_busy_r;
  logic                    user_en_s;
  logic                    clear_wr_s;

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_s      = state_r;
    clear_addr_s = clear_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_s      = ST_CLEAR;
          clear_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s      = ST_IDLE;
          clear_addr_s = clear_addr_r;
        end
      end
      ST_CLEAR: begin
        if (clear_addr_r == LAST_ADDR_L) begin
          state_s      = ST_IDLE;
          clear_addr_s = {ADDR_WIDTH{1'b0}};
        end else begin
          state_s      = ST_CLEAR;
          clear_addr_s = clear_addr_r + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_s      = ST_CLEAR;
        clear_addr_s = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // Sequencer state register; reset always (re)starts a full clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_CLEAR;
      clear_addr_r <= {ADDR_WIDTH{1'b0}};
      clear_busy_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      clear_addr_r <= clear_addr_s;
      clear_busy_r <= (state_s == ST_CLEAR);
    end
  end

  assign clear_busy = clear_busy_r;
  assign user_en_s  = !rst && (state_r == ST_IDLE);
  assign clear_wr_s = !rst && (state_r == ST_CLEAR);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] din_s;
    logic [DATA_WIDTH-1:0] rd_s;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  valid_r;
    logic                  in_range_s;
    logic                  acc_s;
    logic                  wr_s;

    assign addr_s     = address[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_s      = data_in[b*DATA_WIDTH +: DATA_WIDTH];
    assign in_range_s = ({1'b0, addr_s} < DEPTH_L);
    assign acc_s      = user_en_s && chip_sel[b];
    assign wr_s       = acc_s && write_en[b] && in_range_s;

    // Array read; addresses beyond the populated depth read as zero.
    always_comb begin
      rd_s = {DATA_WIDTH{1'b0}};
      if (in_range_s) begin
        rd_s = mem_r[addr_s];
      end else begin
        rd_s = {DATA_WIDTH{1'b0}};
      end
    end

    // Storage array: the sequencer has priority, so user writes never land mid-clear.
    always_ff @(posedge clk) begin
      if (clear_wr_s) begin
        mem_r[clear_addr_r] <= {DATA_WIDTH{1'b0}};
      end else if (wr_s) begin
        mem_r[addr_s] <= din_s;
      end
    end

    // Registered read port with write-first forwarding.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_r  <= {DATA_WIDTH{1'b0}};
        valid_r <= 1'b0;
      end else if (acc_s) begin
        dout_r  <= write_en[b] ? din_s : rd_s;
        valid_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end

    assign data_out[b*DATA_WIDTH +: DATA_WIDTH] = dout_r;
    assign data_valid[b]                        = valid_r;
  end

endmodule

// File: tb/tb_ext_msg_ram_banked.sv
// Self-checking bench for ext_msg_ram_banked: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_ext_msg_ram_banked;

  localparam int NB     = 4;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cs, we;
  logic [31:0] addr, din;
  logic        clr;
  logic        busy;
  logic [31:0] dout;
  logic [3:0]  dv;

  logic [0:0]  cs2, we2;
  logic [7:0]  addr2, din2, dout2;
  logic        clr2, busy2;
  logic [0:0]  dv2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  logic [7:0]  mdl_mem [NB][DEPTH];
  int          busy_left;
  logic [31:0] exp_out;
  logic [3:0]  exp_valid;
  logic        exp_busy;

  always #5 clk = ~clk;

  ext_msg_ram_banked #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RAM_DEPTH(256), .NUM_BANKS(4)) dut (
    .clk(clk), .rst(rst), .chip_sel(cs), .write_en(we), .address(addr), .data_in(din),
    .clear_req(clr), .clear_busy(busy), .data_out(dout), .data_valid(dv));

  ext_msg_ram_banked #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RAM_DEPTH(200), .NUM_BANKS(1)) dut_oor (
    .clk(clk), .rst(rst), .chip_sel(cs2), .write_en(we2), .address(addr2), .data_in(din2),
    .clear_req(clr2), .clear_busy(busy2), .data_out(dout2), .data_valid(dv2));

  // Behavioural model: a clear (or reset) blanks memory and blocks access for DEPTH cycles.
  always @(posedge clk) begin
    if (rst) begin
      busy_left = DEPTH;
      exp_out   = 32'h0;
      exp_valid = 4'h0;
      for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) mdl_mem[b][a] = 8'h00;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      exp_valid = 4'h0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (cs[b]) begin
          exp_valid[b] = 1'b1;
          if (we[b]) begin
            mdl_mem[b][addr[b*8 +: 8]] = din[b*8 +: 8];
            exp_out[b*8 +: 8] = din[b*8 +: 8];
          end else begin
            exp_out[b*8 +: 8] = mdl_mem[b][addr[b*8 +: 8]];
          end
        end else begin
          exp_valid[b] = 1'b0;
        end
      end
      if (clr) begin
        busy_left = DEPTH;
        for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) mdl_mem[b][a] = 8'h00;
      end
    end
    exp_busy = (busy_left > 0);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // counts the cycles busy stays high, starting from a cycle already observed busy
  task automatic count_busy(output int cnt);
    cnt = 1;
    for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
      tick();
      if (busy === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    int bad_valid;
    rst = 1'b1; cs = 4'h0; we = 4'h0; clr = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (busy !== 1'b1 || dv !== 4'h0 || dout !== 32'h0)
      $display("FAIL reset_state: busy=%b valid=%b out=%h, expected 1 0000 00000000", busy, dv, dout);
    else pass_cnt++;
    rst = 1'b0;
    cnt = 1; bad_valid = 0;
    for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
      tick();
      if (dv !== 4'h0) bad_valid++;
      if (busy === 1'b1) cnt++;
    end
    total_cnt++;
    if (cnt !== DEPTH) $display("FAIL reset_clear_len: got %0d cycles, expected %0d", cnt, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (bad_valid !== 0) $display("FAIL reset_valid_low: %0d cycles with valid set, expected 0", bad_valid);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      cs = 4'hF; we = 4'h0; addr = $urandom;
      tick();
      total_cnt++;
      if (dout !== 32'h0 || dv !== 4'hF)
        $display("FAIL reset_read_zero: out=%h valid=%b, expected 00000000 1111", dout, dv);
      else pass_cnt++;
    end
    cs = 4'h0;
  endtask

  task automatic test_parallel();
    cs = 4'hF; we = 4'hF; addr = {4{8'd5}}; din = 32'h44332211;
    tick();
    total_cnt++;
    if (dout !== 32'h44332211 || dv !== 4'hF)
      $display("FAIL parallel_write: out=%h valid=%b, expected 44332211 1111", dout, dv);
    else pass_cnt++;
    we = 4'h0; din = 32'h0;
    tick();
    total_cnt++;
    if (dout !== 32'h44332211 || dv !== 4'hF)
      $display("FAIL parallel_read: out=%h valid=%b, expected 44332211 1111", dout, dv);
    else pass_cnt++;
    cs = 4'h0;
  endtask

  task automatic test_write_first();
    cs = 4'b0100; we = 4'b0100;
    addr = $urandom; addr[23:16] = 8'd9;
    din = $urandom; din[23:16] = 8'hA5;
    tick();
    total_cnt++;
    if (dout[23:16] !== 8'hA5 || dv[2] !== 1'b1)
      $display("FAIL write_first: lane2=%h valid2=%b, expected a5 1", dout[23:16], dv[2]);
    else pass_cnt++;
    we = 4'h0; din = 32'h0;
    tick();
    total_cnt++;
    if (dout[23:16] !== 8'hA5 || dv !== 4'b0100)
      $display("FAIL write_first_read: lane2=%h valid=%b, expected a5 0100", dout[23:16], dv);
    else pass_cnt++;
    cs = 4'h0;
  endtask

  task automatic test_clear_req();
    int cnt;
    for (int i = 0; i < 4; i++) begin
      cs = 4'b0010; we = 4'b0010; addr = 32'h0; addr[15:8] = 8'(i); din = 32'h0; din[15:8] = 8'h7F;
      tick();
    end
    we = 4'h0; addr[15:8] = 8'd2;
    tick();
    total_cnt++;
    if (dout[15:8] !== 8'h7F) $display("FAIL fill_readback: got %h, expected 7f", dout[15:8]);
    else pass_cnt++;
    cs = 4'h0; clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 1;
    for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
      cs = 4'b0010; we = 4'b0010; addr[15:8] = 8'd0; din[15:8] = 8'h55;
      clr = (cnt == 10);
      tick();
      if (busy === 1'b1) cnt++;
    end
    clr = 1'b0;
    total_cnt++;
    if (cnt !== DEPTH) $display("FAIL clear_req_len: got %0d cycles, expected %0d", cnt, DEPTH);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cs = 4'b0010; we = 4'h0; addr[15:8] = 8'(i);
      tick();
      total_cnt++;
      if (dout[15:8] !== 8'h00 || dv !== 4'b0010)
        $display("FAIL cleared_read: addr %0d got %h valid=%b, expected 00 0010", i, dout[15:8], dv);
      else pass_cnt++;
    end
    cs = 4'h0;
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL mid_clear_busy: got %b, expected 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(cnt);
    total_cnt++;
    if (cnt !== DEPTH) $display("FAIL rst_mid_clear_len: got %0d cycles, expected %0d", cnt, DEPTH);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int errs;
    int cnt;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      cs = 4'($urandom); we = 4'($urandom);
      for (int b = 0; b < NB; b++) addr[b*8 +: 8] = 8'($urandom_range(0, 15));
      din = $urandom;
      clr = ($urandom_range(0, 199) == 0);
      tick();
      total_cnt++;
      if ({busy, dv, dout} !== {exp_busy, exp_valid, exp_out}) begin
        errs++;
        if (errs < 10)
          $display("FAIL random_cycle %0d: busy/valid/out=%b/%b/%h, expected %b/%b/%h",
                   i, busy, dv, dout, exp_busy, exp_valid, exp_out);
      end else pass_cnt++;
    end
    cs = 4'h0; clr = 1'b0;
    if (busy === 1'b1) count_busy(cnt);
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 400 && busy2 !== 1'b0; i++) tick();
    total_cnt++;
    if (busy2 !== 1'b0) $display("FAIL oor_idle: busy=%b, expected 0", busy2);
    else pass_cnt++;
    cs2 = 1'b1; we2 = 1'b1; addr2 = 8'd210; din2 = 8'h3C;
    tick();
    we2 = 1'b0; din2 = 8'h00;
    tick();
    total_cnt++;
    if (dout2 !== 8'h00 || dv2 !== 1'b1) $display("FAIL oor_read: got %h valid=%b, expected 00 1", dout2, dv2);
    else pass_cnt++;
    we2 = 1'b1; addr2 = 8'd199; din2 = 8'h3C;
    tick();
    we2 = 1'b0; din2 = 8'h00;
    tick();
    total_cnt++;
    if (dout2 !== 8'h3C || dv2 !== 1'b1) $display("FAIL last_addr_read: got %h valid=%b, expected 3c 1", dout2, dv2);
    else pass_cnt++;
    addr2 = 8'd210;
    tick();
    total_cnt++;
    if (dout2 !== 8'h00 || dv2 !== 1'b1) $display("FAIL oor_reread: got %h valid=%b, expected 00 1", dout2, dv2);
    else pass_cnt++;
    cs2 = 1'b0;
    tick();
    total_cnt++;
    if (dv2 !== 1'b0 || dout2 !== 8'h00) $display("FAIL oor_hold: got %h valid=%b, expected 00 0", dout2, dv2);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; cs = 4'h0; we = 4'h0; addr = 32'h0; din = 32'h0; clr = 1'b0;
    cs2 = 1'b0; we2 = 1'b0; addr2 = 8'h0; din2 = 8'h0; clr2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_parallel();
    test_write_first();
    test_clear_req();
    test_reset_mid_clear();
    test_random();
    test_out_of_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
